plusarg_watchdog_ctrl: RTL

- Simulation/harness cycle watchdog that sequences a plusarg-supplied cycle limit.
- A plusarg reader drives `cfg_limit` (0 = disabled).
- A heartbeat `kick` restarts the count; a warning phase precedes a sticky expiry.
- Software/test logic may override the limit through a valid/ready port.
- Sits in the harness next to the plusarg readers and feeds the sim-finish/error logic.

---
 rtl/plusarg_watchdog_pkg.sv | 14 +
 rtl/plusarg_watchdog_ctrl_if.sv | 11 +
 rtl/plusarg_watchdog_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/plusarg_watchdog_pkg.sv
// Shared types for the plusarg cycle watchdog: the state encoding seen on the
// `state` output and the width that carries it.
package plusarg_watchdog_pkg;

    localparam int WD_STATE_W = 2;

    typedef enum logic [WD_STATE_W-1:0] {
        WD_IDLE    = 2'd0,
        WD_RUN     = 2'd1,
        WD_WARN    = 2'd2,
        WD_EXPIRED = 2'd3
    } wd_state_e;

endpackage

// File: rtl/plusarg_watchdog_ctrl_if.sv
// Limit-override handshake between test/software logic (master) and the watchdog (slave).
interface plusarg_watchdog_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             ovr_valid;
    logic [WIDTH-1:0] ovr_limit;
    logic             ovr_ready;

    modport master (output ovr_valid, output ovr_limit, input ovr_ready);
    modport slave  (input ovr_valid, input ovr_limit, output ovr_ready);
endinterface

// File: rtl/plusarg_watchdog_ctrl.sv
// Harness cycle watchdog: counts cycles since the last kick against a plusarg or
// overridden limit, raising warn near the limit and a sticky expiry at it.
module plusarg_watchdog_ctrl
    import plusarg_watchdog_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int WARN_SHIFT = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [WIDTH-1:0]      cfg_limit,
    input  logic                  cfg_enable,
    input  logic                  kick,
    plusarg_watchdog_ctrl_if.slave ovr,
    output logic [WD_STATE_W-1:0] state,
    output logic [WIDTH-1:0]      count,
    output logic                  warn,
    output logic                  expired,
    output logic                  expired_pulse
);

    wd_state_e        state_reg, state_next;
    logic [WIDTH-1:0] count_reg, count_next;
    logic [WIDTH-1:0] limit_reg, limit_next;
    logic             ovr_seen_reg, ovr_seen_next;
    logic             pulse_reg, pulse_next;
    logic [WIDTH-1:0] thr;
    logic [WIDTH-1:0] count_inc;
    logic             ovr_fire;

    // thr <= limit_reg always, so the subtraction cannot underflow.
    assign thr       = limit_reg - (limit_reg >> WARN_SHIFT);
    assign count_inc = count_reg + WIDTH'(1);

    assign ovr.ovr_ready = reset_n && (state_reg != WD_EXPIRED);
    assign ovr_fire      = ovr.ovr_valid && ovr.ovr_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= WD_IDLE;
            count_reg    <= '0;
            limit_reg    <= '0;
            ovr_seen_reg <= 1'b0;
            pulse_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            limit_reg    <= limit_next;
            ovr_seen_reg <= ovr_seen_next;
            pulse_reg    <= pulse_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        limit_next    = limit_reg;
        ovr_seen_next = ovr_seen_reg;
        pulse_next    = 1'b0;

        if (ovr_fire) begin
            limit_next    = ovr.ovr_limit;
            ovr_seen_next = 1'b1;
            count_next    = '0;
            state_next    = (cfg_enable && (ovr.ovr_limit != '0)) ? WD_RUN : WD_IDLE;
        end else begin
            case (state_reg)
                WD_IDLE: begin
                    count_next = '0;
                    // Once overridden, the plusarg value no longer tracks in.
                    if (!ovr_seen_reg) begin
                        limit_next = cfg_limit;
                    end
                    if (cfg_enable && (limit_reg != '0)) begin
                        state_next = WD_RUN;
                    end
                end
                WD_RUN, WD_WARN: begin
                    if (!cfg_enable) begin
                        state_next = WD_IDLE;
                        count_next = '0;
                    end else if (kick) begin
                        state_next = WD_RUN;
                        count_next = '0;
                    end else if (count_inc >= limit_reg) begin
                        state_next = WD_EXPIRED;
                        count_next = limit_reg;
                        pulse_next = 1'b1;
                    end else if (count_inc >= thr) begin
                        state_next = WD_WARN;
                        count_next = count_inc;
                    end else begin
                        count_next = count_inc;
                    end
                end
                WD_EXPIRED: begin
                    state_next = WD_EXPIRED;
                end
                default: begin
                    state_next = WD_IDLE;
                    count_next = '0;
                end
            endcase
        end
    end

    assign state         = state_reg;
    assign count         = count_reg;
    assign warn          = (state_reg == WD_WARN);
    assign expired       = (state_reg == WD_EXPIRED);
    assign expired_pulse = pulse_reg;

endmodule
